// File: rtl/dmem_bus_pkg.sv
// ============================================================================
// dmem_bus_pkg : shared types and constants for the data-memory bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0]  MASK_B    = 2'd0;
  localparam logic [1:0]  MASK_H    = 2'd1;
  localparam logic [1:0]  MASK_W    = 2'd2;

  // Read data returned with a timeout error response
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational two-way round-robin picker
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic       gnt_o,
  output logic       id_o
);

  assign gnt_o = |req_i;
  // On contention, the master that was not granted last wins
  assign id_o  = (&req_i) ? ~rr_ptr_i : req_i[1];

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-master, one-target data-memory arbiter with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_valid_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic          m0_wen_i,
  input  logic [1:0]    m0_mask_i,
  output logic          m0_good_o,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_err_o,
  input  logic          m1_valid_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_wen_i,
  input  logic [1:0]    m1_mask_i,
  output logic          m1_good_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_err_o,
  output logic          tgt_valid_o,
  output logic [AW-1:0] tgt_addr_o,
  output logic [DW-1:0] tgt_wdata_o,
  output logic          tgt_wen_o,
  output logic [1:0]    tgt_mask_o,
  input  logic          tgt_ready_i,
  input  logic [DW-1:0] tgt_rdata_i,
  output logic          busy_o,
  output logic          grant_id_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic [1:0]    mask_q, mask_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          arb_gnt;
  logic          arb_id;

  rr_arb2 u_rr_arb2 (
    .req_i    ({m1_valid_i, m0_valid_i}),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .id_o     (arb_id)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wen_d    = wen_q;
    mask_d   = mask_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_gnt) begin
          grant_d  = arb_id;
          rr_ptr_d = arb_id;
          addr_d   = arb_id ? m1_addr_i  : m0_addr_i;
          wdata_d  = arb_id ? m1_wdata_i : m0_wdata_i;
          wen_d    = arb_id ? m1_wen_i   : m0_wen_i;
          mask_d   = arb_id ? m1_mask_i  : m0_mask_i;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // A ready in the final timeout cycle still completes cleanly
        if (tgt_ready_i) begin
          rdata_d = tgt_rdata_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = DW'(ERR_RDATA);
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      mask_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m0_good_o   = (state_q == RESP) && !grant_q;
  assign m1_good_o   = (state_q == RESP) &&  grant_q;
  assign m0_rdata_o  = m0_good_o ? rdata_q : '0;
  assign m1_rdata_o  = m1_good_o ? rdata_q : '0;
  assign m0_err_o    = m0_good_o & err_q;
  assign m1_err_o    = m1_good_o & err_q;

  assign tgt_valid_o = (state_q == REQ);
  assign tgt_addr_o  = addr_q;
  assign tgt_wdata_o = wdata_q;
  assign tgt_wen_o   = wen_q;
  assign tgt_mask_o  = mask_q;
  assign busy_o      = (state_q != IDLE);
  assign grant_id_o  = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed self-checking bench for dmem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_valid, m1_valid, m0_wen, m1_wen;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [1:0]  m0_mask, m1_mask;
  logic        m0_good, m1_good, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        tgt_valid, tgt_wen, tgt_ready, busy, grant_id;
  logic [31:0] tgt_addr, tgt_wdata, tgt_rdata;
  logic [1:0]  tgt_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_valid_i  (m0_valid),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_wen_i    (m0_wen),
    .m0_mask_i   (m0_mask),
    .m0_good_o   (m0_good),
    .m0_rdata_o  (m0_rdata),
    .m0_err_o    (m0_err),
    .m1_valid_i  (m1_valid),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_wen_i    (m1_wen),
    .m1_mask_i   (m1_mask),
    .m1_good_o   (m1_good),
    .m1_rdata_o  (m1_rdata),
    .m1_err_o    (m1_err),
    .tgt_valid_o (tgt_valid),
    .tgt_addr_o  (tgt_addr),
    .tgt_wdata_o (tgt_wdata),
    .tgt_wen_o   (tgt_wen),
    .tgt_mask_o  (tgt_mask),
    .tgt_ready_i (tgt_ready),
    .tgt_rdata_i (tgt_rdata),
    .busy_o      (busy),
    .grant_id_o  (grant_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic exp_id;
    logic [31:0] rd;

    rst_n = 1'b0;
    {m0_valid, m1_valid, m0_wen, m1_wen} = '0;
    {m0_addr, m1_addr, m0_wdata, m1_wdata} = '0;
    {m0_mask, m1_mask} = '0;
    tgt_ready = 1'b0;
    tgt_rdata = '0;
    step();
    step();

    // Reset state
    check("rst_busy",      busy,      0);
    check("rst_tgt_valid", tgt_valid, 0);
    check("rst_m0_good",   m0_good,   0);
    check("rst_m1_good",   m1_good,   0);
    check("rst_grant",     grant_id,  0);
    check("rst_tgt_addr",  tgt_addr,  0);
    check("rst_tgt_wen",   tgt_wen,   0);
    rst_n = 1'b1;
    step();

    // Single CPU read, zero-wait target
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wen = 1'b0; m0_mask = 2'd2;
    step();
    check("rd_tgt_valid", tgt_valid, 1);
    check("rd_tgt_addr",  tgt_addr,  32'h100);
    check("rd_grant",     grant_id,  0);
    check("rd_busy",      busy,      1);
    tgt_ready = 1'b1; tgt_rdata = 32'h12345678;
    step();
    check("rd_m0_good",  m0_good,  1);
    check("rd_m0_rdata", m0_rdata, 32'h12345678);
    check("rd_m0_err",   m0_err,   0);
    check("rd_m1_good",  m1_good,  0);
    check("rd_m1_rdata", m1_rdata, 0);
    check("rd_resp_tv",  tgt_valid, 0);
    m0_valid = 1'b0; tgt_ready = 1'b0;
    step();
    check("rd_m0_pulse", m0_good, 0);
    check("rd_idle",     busy,    0);

    // m1 write with four wait cycles
    m1_valid = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'hCAFEF00D; m1_wen = 1'b1; m1_mask = 2'd2;
    tgt_rdata = 32'h5555AAAA;
    step();
    for (int i = 0; i < 4; i++) begin
      check("wr_tgt_valid", tgt_valid, 1);
      check("wr_tgt_addr",  tgt_addr,  32'h2000);
      check("wr_tgt_wdata", tgt_wdata, 32'hCAFEF00D);
      check("wr_tgt_mask",  tgt_mask,  2);
      check("wr_tgt_wen",   tgt_wen,   1);
      check("wr_m1_early",  m1_good,   0);
      step();
    end
    check("wr_still_req", tgt_valid, 1);
    tgt_ready = 1'b1;
    step();
    check("wr_m1_good", m1_good,  1);
    check("wr_m0_good", m0_good,  0);
    check("wr_grant",   grant_id, 1);
    check("wr_m1_err",  m1_err,   0);
    m1_valid = 1'b0; tgt_ready = 1'b0;
    step();
    check("wr_m1_pulse", m1_good, 0);

    // Contention from reset: expect m1, m0, m1, m0
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wen = 1'b0;
    m1_valid = 1'b1; m1_addr = 32'h20; m1_wen = 1'b0;
    tgt_ready = 1'b1;
    exp_id = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tgt_rdata = 32'hA000_0000 + k;
      step();
      check("cn_grant",   grant_id, exp_id);
      check("cn_tgt_addr", tgt_addr, exp_id ? 32'h20 : 32'h10);
      step();
      check("cn_m0_good", m0_good, !exp_id);
      check("cn_m1_good", m1_good, exp_id);
      check("cn_rdata",   exp_id ? m1_rdata : m0_rdata, 32'hA000_0000 + k);
      if (exp_id) m1_valid = 1'b0; else m0_valid = 1'b0;
      step();
      check("cn_pulse", m0_good | m1_good, 0);
      if (exp_id) m1_valid = 1'b1; else m0_valid = 1'b1;
      exp_id = ~exp_id;
    end
    m0_valid = 1'b0; m1_valid = 1'b0; tgt_ready = 1'b0;
    step();
    step();

    // Timeout: ready stuck low, TIMEOUT=8
    m0_valid = 1'b1; m0_addr = 32'h300; tgt_rdata = 32'hDEADBEEF;
    step();
    n = 0;
    while (tgt_valid && n < 20) begin
      n++;
      step();
    end
    check("to_req_cycles", n,        8);
    check("to_m0_good",    m0_good,  1);
    check("to_m0_err",     m0_err,   1);
    check("to_m0_rdata",   m0_rdata, 0);
    m0_valid = 1'b0;
    step();
    check("to_idle", busy, 0);

    // Ready arrives in the last timeout cycle
    m0_valid = 1'b1; m0_addr = 32'h304; tgt_rdata = 32'hA5A55A5A;
    step();
    for (int i = 0; i < 7; i++) step();
    check("tie_still_req", tgt_valid, 1);
    tgt_ready = 1'b1;
    step();
    check("tie_m0_good",  m0_good,  1);
    check("tie_m0_err",   m0_err,   0);
    check("tie_m0_rdata", m0_rdata, 32'hA5A55A5A);
    m0_valid = 1'b0; tgt_ready = 1'b0;
    step();

    // Reset asserted mid-REQ
    m0_valid = 1'b1; m0_addr = 32'h400;
    step();
    check("mr_in_req", tgt_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_tgt_valid", tgt_valid, 0);
    check("mr_busy",      busy,      0);
    check("mr_m0_good",   m0_good,   0);
    m0_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("mr_after_idle", busy, 0);
    m0_valid = 1'b1; m0_addr = 32'h40; tgt_ready = 1'b1; tgt_rdata = 32'h0BADBEEF;
    step();
    check("mr_fresh_addr", tgt_addr, 32'h40);
    step();
    check("mr_fresh_good",  m0_good,  1);
    check("mr_fresh_rdata", m0_rdata, 32'h0BADBEEF);
    m0_valid = 1'b0; tgt_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
